// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   state_e       : arbiter FSM states (ARB, START, WAIT, GAP)
//   DEFAULT_CPB   : default PCLK cycles per UART bit
//   FRAME_BITS    : bits per UART frame (start + 8 data + stop)
//   idx_width()   : width of an index into n requesters (at least 1 bit)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int DEFAULT_CPB = 87;
    localparam int FRAME_BITS  = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the transmitter control signals.
//   req_valid/req_data/req_ready : NREQ byte requesters (byte i at [8i+7:8i])
//   tx_start/tx_data/tx_done     : UART transmitter control
//   grant_id/busy/err_timeout    : status
// Modports: master = arbiter side, slave = requester/transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int IDW = idx_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_start, tx_data, grant_id, busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : index granted last time; search starts at last_i+1 (circular)
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : index of the winner
//   any_o  : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    // cand[k] is the requester examined k-th in priority order.
    logic [IDW-1:0] cand [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = IDW'((int'(last_i) + 1 + gi) % NREQ);
        end
    endgenerate

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Walk from lowest to highest priority so the highest-priority hit
        // is the final assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                idx_o = cand[k];
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NREQ byte requesters, round robin.
// Accepts one byte, pulses tx_start, waits for tx_done (with watchdog),
// then idles GAP cycles before arbitrating again.
//   PCLK   : clock, rising edge
//   PRESET : asynchronous active-high reset
//   bus    : requester handshake, transmitter control and status
// Everything except req_ready is registered.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CPB     = DEFAULT_CPB,
    parameter int GAP     = 0,
    parameter int TIMEOUT = (FRAME_BITS + 2) * CPB
) (
    input  logic PCLK,
    input  logic PRESET,
    uart_tx_arbiter_if.master bus
);
    localparam int IDW = idx_width(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);
    localparam logic [7:0]     GAP_LAST = 8'(GAP - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [7:0]     gap_q, gap_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            wd_expired;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign wd_expired = (wd_q == WD_LIMIT);

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_ARB;
            last_q     <= IDW'(NREQ - 1);  // requester 0 wins first
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (pick_any) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.tx_done || wd_expired) begin
                    state_d = (GAP == 0) ? ST_ARB : ST_GAP;
                end
            end
            ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        last_d    = last_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        // Registered outputs look one state ahead so they line up with it.
        tx_start_d = (state_d == ST_START);
        busy_d     = (state_d != ST_ARB);
        // A done arriving on the expiry cycle takes precedence.
        err_d      = (state_q == ST_WAIT) && !bus.tx_done && wd_expired;
        case (state_q)
            ST_ARB: begin
                if (pick_any) begin
                    tx_data_d = bus.req_data[int'(pick_idx) * 8 +: 8];
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                end
            end
            // The start cycle counts as the first watchdog cycle, so the
            // error pulse lands TIMEOUT cycles after tx_start.
            ST_START: wd_d = WDW'(1);
            ST_WAIT: begin
                wd_d  = wd_q + WDW'(1);
                gap_d = '0;
            end
            ST_GAP:   gap_d = gap_q + 8'd1;
            default:  ;
        endcase
    end

    assign bus.req_ready   = (state_q == ST_ARB) ? pick_gnt : '0;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench: a per-cycle vector table for reset and the first frame,
// then hand-written sequences for alternation, timeout, mid-frame reset and
// the inter-frame gap (second instance with GAP=4). CPB=4, TIMEOUT=48.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int CPB_TB = 4;
    localparam int FRAME  = 10 * CPB_TB;  // transmitter done delay
    localparam int TO     = 12 * CPB_TB;  // watchdog limit

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    uart_tx_arbiter_if #(.NREQ(2)) ifa ();
    uart_tx_arbiter_if #(.NREQ(2)) ifb ();

    uart_tx_arbiter #(.NREQ(2), .CPB(CPB_TB), .GAP(0)) dut_a (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (ifa)
    );

    uart_tx_arbiter #(.NREQ(2), .CPB(CPB_TB), .GAP(4)) dut_b (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (ifb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] data;
        logic        done;
        logic [1:0]  e_ready;
        logic        e_start;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_grant;
        logic        e_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Called settled in an ARB cycle where requester g should win.
    task automatic frame_a(input int g, input logic [7:0] d, input logic [1:0] clr,
                           input int done_after);
        logic [1:0] oh;
        oh = 2'b01 << g;
        chk("arb_ready", ifa.req_ready, oh);
        cyc();
        ifa.req_valid = ifa.req_valid & ~clr;
        settle();
        chk("start", ifa.tx_start, 1);
        chk("tx_data", ifa.tx_data, d);
        chk("grant", ifa.grant_id, g);
        chk("busy_start", ifa.busy, 1);
        chk("ready_busy", ifa.req_ready, 0);
        $display("TX dut_a grant=%0d data=%02h t=%0t", ifa.grant_id, ifa.tx_data, $time);
        for (int k = 1; k < done_after; k++) begin
            cyc();
            settle();
        end
        cyc();
        ifa.tx_done = 1'b1;
        settle();
        chk("busy_done", ifa.busy, 1);
        cyc();
        ifa.tx_done = 1'b0;
        settle();
        chk("busy_after", ifa.busy, 0);
        chk("err_after", ifa.err_timeout, 0);
    endtask

    initial begin
        ifa.req_valid = '0; ifa.req_data = '0; ifa.tx_done = 1'b0;
        ifb.req_valid = '0; ifb.req_data = '0; ifb.tx_done = 1'b0;

        //            rst   valid  data      done  ready  start data   busy  grant err
        vecs[0] = '{1'b1, 2'b00, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 16'h00CC, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b00, 16'h00CC, 1'b0, 2'b00, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b00, 16'h00CC, 1'b0, 2'b00, 1'b0, 8'hCC, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 2'b10, 16'h3300, 1'b0, 2'b00, 1'b0, 8'hCC, 1'b1, 1'b0, 1'b0};

        repeat (2) cyc();

        // Reset, idle, spurious done, first frame start
        for (int i = 0; i < 8; i++) begin
            cyc();
            PRESET        = vecs[i].rst;
            ifa.req_valid = vecs[i].valid;
            ifa.req_data  = vecs[i].data;
            ifa.tx_done   = vecs[i].done;
            settle();
            chk("v_ready", ifa.req_ready, vecs[i].e_ready);
            chk("v_start", ifa.tx_start, vecs[i].e_start);
            chk("v_data", ifa.tx_data, vecs[i].e_data);
            chk("v_busy", ifa.busy, vecs[i].e_busy);
            chk("v_grant", ifa.grant_id, vecs[i].e_grant);
            chk("v_err", ifa.err_timeout, vecs[i].e_err);
        end
        $display("TX dut_a vector frame grant=0 data=cc");
        // vecs[5] was the start cycle s; vecs[7] is s+2. Done at s+FRAME.
        for (int k = 3; k < FRAME; k++) begin
            cyc();
            settle();
            chk("wait_busy", ifa.busy, 1);
            chk("wait_ready", ifa.req_ready, 0);
        end
        cyc();
        ifa.tx_done = 1'b1;
        settle();
        chk("done_busy", ifa.busy, 1);
        cyc();
        ifa.tx_done = 1'b0;
        settle();
        chk("busy_fall", ifa.busy, 0);
        // Pending requester 1 is served after exactly one ARB cycle.
        frame_a(1, 8'h33, 2'b10, 5);

        // Alternation with both requesters held valid
        cyc();
        PRESET = 1'b1;
        ifa.req_valid = 2'b11;
        ifa.req_data  = 16'h3CA5;
        settle();
        cyc();
        PRESET = 1'b0;
        settle();
        frame_a(0, 8'hA5, 2'b00, FRAME);
        frame_a(1, 8'h3C, 2'b00, FRAME);
        frame_a(0, 8'hA5, 2'b00, FRAME);
        frame_a(1, 8'h3C, 2'b00, FRAME);

        // Watchdog expiry: requester 0 frame never completes
        chk("to_ready", ifa.req_ready, 2'b01);
        cyc();
        ifa.req_valid = 2'b10;
        settle();
        chk("to_start", ifa.tx_start, 1);
        chk("to_grant", ifa.grant_id, 0);
        for (int k = 1; k < TO; k++) begin
            cyc();
            settle();
        end
        chk("to_err_early", ifa.err_timeout, 0);
        chk("to_busy_early", ifa.busy, 1);
        cyc();
        settle();
        chk("to_err_pulse", ifa.err_timeout, 1);
        chk("to_busy_off", ifa.busy, 0);
        chk("to_next_ready", ifa.req_ready, 2'b10);
        $display("TX dut_a timeout err=%0d t=%0t", ifa.err_timeout, $time);
        cyc();
        ifa.req_valid = 2'b00;
        settle();
        chk("to_err_once", ifa.err_timeout, 0);
        chk("to2_start", ifa.tx_start, 1);
        chk("to2_data", ifa.tx_data, 8'h3C);
        chk("to2_grant", ifa.grant_id, 1);
        // Done on the expiry cycle: no error
        for (int k = 1; k < TO - 1; k++) begin
            cyc();
            settle();
        end
        cyc();
        ifa.tx_done = 1'b1;
        settle();
        cyc();
        ifa.tx_done = 1'b0;
        settle();
        chk("tie_err", ifa.err_timeout, 0);
        chk("tie_busy", ifa.busy, 0);
        $display("TX dut_a done-at-expiry err=%0d t=%0t", ifa.err_timeout, $time);

        // Reset in the middle of a frame
        ifa.req_valid = 2'b01;
        ifa.req_data  = 16'h00CC;
        #1;
        chk("mr_ready", ifa.req_ready, 2'b01);
        cyc();
        ifa.req_valid = 2'b00;
        settle();
        chk("mr_start", ifa.tx_start, 1);
        repeat (2) begin
            cyc();
            settle();
        end
        chk("mr_busy_pre", ifa.busy, 1);
        chk("mr_data_pre", ifa.tx_data, 8'hCC);
        cyc();
        PRESET = 1'b1;
        #1;
        chk("mr_data_async", ifa.tx_data, 0);
        chk("mr_busy_async", ifa.busy, 0);
        chk("mr_start_async", ifa.tx_start, 0);
        chk("mr_err_async", ifa.err_timeout, 0);
        cyc();
        PRESET = 1'b0;
        ifa.tx_done = 1'b1;
        settle();
        cyc();
        ifa.tx_done = 1'b0;
        settle();
        chk("mr_spur_busy", ifa.busy, 0);
        chk("mr_spur_start", ifa.tx_start, 0);
        chk("mr_spur_err", ifa.err_timeout, 0);
        ifa.req_valid = 2'b11;
        ifa.req_data  = 16'h3CA5;
        #1;
        chk("mr_req0_first", ifa.req_ready, 2'b01);
        cyc();
        ifa.req_valid = 2'b10;
        settle();
        chk("mr_start2", ifa.tx_start, 1);
        chk("mr_data2", ifa.tx_data, 8'hA5);
        chk("mr_grant2", ifa.grant_id, 0);
        $display("TX dut_a after reset grant=%0d data=%02h t=%0t", ifa.grant_id, ifa.tx_data, $time);

        // Inter-frame gap of 4 cycles on the second instance
        ifb.req_valid = 2'b01;
        ifb.req_data  = 16'h00CC;
        #1;
        chk("gap_ready0", ifb.req_ready, 2'b01);
        cyc();
        settle();
        chk("gap_start", ifb.tx_start, 1);
        chk("gap_data", ifb.tx_data, 8'hCC);
        for (int k = 1; k < 5; k++) begin
            cyc();
            settle();
        end
        cyc();
        ifb.tx_done = 1'b1;
        settle();
        cyc();
        ifb.tx_done = 1'b0;
        settle();
        for (int k = 1; k < 5; k++) begin
            if (k > 1) begin
                cyc();
                settle();
            end
            chk("gap_hold_ready", ifb.req_ready, 0);
            chk("gap_hold_busy", ifb.busy, 1);
        end
        cyc();
        settle();
        chk("gap_ready5", ifb.req_ready, 2'b01);
        chk("gap_busy_off", ifb.busy, 0);
        $display("TX dut_b gap frame ready=%0b t=%0t", ifb.req_ready, $time);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
